// File: rtl/udp_clk_pkg.sv
// Shared types and constants for the UDP reference-clock timebase.
// Holds the FSM state encoding and the config validation rule.
package udp_clk_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_PERIOD = 100;
  localparam int DEFAULT_THRESH = 49;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ARMED = 2'd2
  } state_t;

  // Arguments are widened to 64 bits so any WIDTH up to 64 can reuse the rule.
  function automatic logic is_cfg_valid(input logic [63:0] period, input logic [63:0] thresh);
    return (period >= 64'd2) && (thresh < period);
  endfunction

endpackage

// File: rtl/udp_cfg_shadow.sv
// Double-buffered period/threshold registers with validation and apply strobe.
// The FSM in the top decides whether an accepted config lands directly or waits.
module udp_cfg_shadow #(
  parameter int WIDTH          = 32,
  parameter int DEFAULT_PERIOD = 100,
  parameter int DEFAULT_THRESH = 49
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             accept,
  input  logic             direct,
  input  logic             commit,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_thresh,
  output logic             cfg_ok,
  output logic [WIDTH-1:0] period_active,
  output logic [WIDTH-1:0] condition,
  output logic             cfg_err,
  output logic             cfg_applied
);
  import udp_clk_pkg::*;

  logic [WIDTH-1:0] shadow_period_r;
  logic [WIDTH-1:0] shadow_thresh_r;
  logic             pending_r;

  assign cfg_ok = is_cfg_valid(64'(cfg_period), 64'(cfg_thresh));

  // Active/shadow register update; commit of a pending config has priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_period_r <= '0;
      shadow_thresh_r <= '0;
      pending_r       <= 1'b0;
      period_active   <= WIDTH'(DEFAULT_PERIOD);
      condition       <= WIDTH'(DEFAULT_THRESH);
      cfg_err         <= 1'b0;
      cfg_applied     <= 1'b0;
    end else begin
      cfg_err     <= accept && !cfg_ok;
      cfg_applied <= 1'b0;
      if (commit && pending_r) begin
        period_active <= shadow_period_r;
        condition     <= shadow_thresh_r;
        pending_r     <= 1'b0;
        cfg_applied   <= 1'b1;
      end else if (accept && cfg_ok && direct) begin
        period_active <= cfg_period;
        condition     <= cfg_thresh;
        cfg_applied   <= 1'b1;
      end else if (accept && cfg_ok) begin
        shadow_period_r <= cfg_period;
        shadow_thresh_r <= cfg_thresh;
        pending_r       <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

endmodule

// File: rtl/udp_period_counter.sv
// Wrapping timebase counter and threshold for the UDP reference-clock comparator.
// New period/threshold take effect only at a wrap so the derived clock has no runt pulse.
module udp_period_counter #(
  parameter int WIDTH          = udp_clk_pkg::DEFAULT_WIDTH,
  parameter int DEFAULT_PERIOD = udp_clk_pkg::DEFAULT_PERIOD,
  parameter int DEFAULT_THRESH = udp_clk_pkg::DEFAULT_THRESH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_thresh,
  output logic             cfg_err,
  output logic             cfg_applied,
  output logic [WIDTH-1:0] counter,
  output logic [WIDTH-1:0] condition,
  output logic             wrap
);
  import udp_clk_pkg::*;

  state_t           state_r;
  state_t           next_state_s;
  logic [WIDTH-1:0] counter_r;
  logic [WIDTH-1:0] count_next_s;
  logic             wrap_r;
  logic             wrap_next_s;
  logic             cfg_ready_r;
  logic             accept_s;
  logic             direct_s;
  logic             commit_s;
  logic             cfg_ok_s;
  logic             last_s;
  logic [WIDTH-1:0] period_active_s;

  assign accept_s = cfg_valid && cfg_ready_r;
  assign last_s   = (counter_r == (period_active_s - WIDTH'(1)));

  udp_cfg_shadow #(
    .WIDTH          (WIDTH),
    .DEFAULT_PERIOD (DEFAULT_PERIOD),
    .DEFAULT_THRESH (DEFAULT_THRESH)
  ) u_cfg_shadow (
    .clk           (clk),
    .reset         (reset),
    .accept        (accept_s),
    .direct        (direct_s),
    .commit        (commit_s),
    .cfg_period    (cfg_period),
    .cfg_thresh    (cfg_thresh),
    .cfg_ok        (cfg_ok_s),
    .period_active (period_active_s),
    .condition     (condition),
    .cfg_err       (cfg_err),
    .cfg_applied   (cfg_applied)
  );

  // Next-state, next-count and config routing; a config accepted on a rollover edge waits.
  always_comb begin
    next_state_s = state_r;
    count_next_s = counter_r;
    wrap_next_s  = 1'b0;
    direct_s     = 1'b0;
    commit_s     = 1'b0;
    case (state_r)
      IDLE: begin
        count_next_s = '0;
        direct_s     = 1'b1;
        next_state_s = enable ? RUN : IDLE;
      end
      RUN, ARMED: begin
        if (!enable) begin
          next_state_s = IDLE;
          count_next_s = '0;
          direct_s     = 1'b1;
          commit_s     = 1'b1;
        end else begin
          if (last_s) begin
            count_next_s = '0;
            wrap_next_s  = 1'b1;
            commit_s     = 1'b1;
            next_state_s = RUN;
          end else begin
            count_next_s = counter_r + WIDTH'(1);
            next_state_s = state_r;
          end
          next_state_s = (accept_s && cfg_ok_s) ? ARMED : next_state_s;
        end
      end
      default: begin
        next_state_s = IDLE;
        count_next_s = '0;
      end
    endcase
  end

  // State, counter and handshake registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      counter_r   <= '0;
      wrap_r      <= 1'b0;
      cfg_ready_r <= 1'b1;
    end else begin
      state_r     <= next_state_s;
      counter_r   <= count_next_s;
      wrap_r      <= wrap_next_s;
      cfg_ready_r <= (next_state_s != ARMED);
    end
  end

  assign counter   = counter_r;
  assign wrap      = wrap_r;
  assign cfg_ready = cfg_ready_r;

endmodule

// File: tb/tb_udp_period_counter.sv
// Scoreboard bench for udp_period_counter: a rule-level model predicts every cycle's
// outputs into a queue, and a monitor compares them against the DUT after each edge.
module tb_udp_period_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_period = 32'd0;
  logic [31:0] cfg_thresh = 32'd0;
  logic        cfg_err;
  logic        cfg_applied;
  logic [31:0] counter;
  logic [31:0] condition;
  logic        wrap;

  udp_period_counter dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_period  (cfg_period),
    .cfg_thresh  (cfg_thresh),
    .cfg_err     (cfg_err),
    .cfg_applied (cfg_applied),
    .counter     (counter),
    .condition   (condition),
    .wrap        (wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cnt;
    logic [31:0] cond;
    logic        wrp;
    logic        appl;
    logic        err;
    logic        rdy;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  // Reference model: counting flag, count, active and pending config.
  bit        m_run = 1'b0;
  bit        m_pend = 1'b0;
  int unsigned m_cnt = 0, m_per = 100, m_thr = 49, m_sp = 0, m_st = 0;
  bit        e_wrap, e_appl, e_err;

  bit measure = 1'b0;
  int hi_cnt = 0;

  task automatic model_step(bit rst, bit en, bit v, int unsigned p, int unsigned t);
    bit acc, ok, roll, was_run;
    if (rst) begin
      m_run = 0; m_pend = 0; m_cnt = 0; m_per = 100; m_thr = 49; m_sp = 0; m_st = 0;
      e_wrap = 0; e_appl = 0; e_err = 0;
    end else begin
      acc     = v && !m_pend;
      ok      = (p >= 2) && (t < p);
      was_run = m_run;
      roll    = m_run && en && (m_cnt == m_per - 1);
      e_wrap  = 0;
      e_appl  = 0;
      e_err   = acc && !ok;
      if (!m_run) begin
        m_cnt = 0;
        m_run = en;
      end else if (!en) begin
        m_cnt = 0;
        m_run = 0;
      end else if (roll) begin
        m_cnt  = 0;
        e_wrap = 1;
      end else begin
        m_cnt = m_cnt + 1;
      end
      if (m_pend && (!en || roll)) begin
        m_per = m_sp; m_thr = m_st; m_pend = 0; e_appl = 1;
      end
      if (acc && ok) begin
        if (!was_run || !en) begin
          m_per = p; m_thr = t; e_appl = 1;
        end else begin
          m_sp = p; m_st = t; m_pend = 1;
        end
      end
    end
  endtask

  task automatic cycle(bit rst, bit en, bit v, int unsigned p, int unsigned t);
    obs_t e;
    @(negedge clk);
    if (measure && (counter > condition)) hi_cnt++;
    reset      = rst;
    enable     = en;
    cfg_valid  = v;
    cfg_period = p;
    cfg_thresh = t;
    model_step(rst, en, v, p, t);
    e.cnt  = m_cnt;
    e.cond = m_thr;
    e.wrp  = e_wrap;
    e.appl = e_appl;
    e.err  = e_err;
    e.rdy  = !m_pend;
    exp_q.push_back(e);
  endtask

  task automatic run_until(int unsigned target);
    int n = 0;
    while (!(m_run && m_cnt == target) && n < 1000) begin
      cycle(0, 1, 0, 0, 0);
      n++;
    end
    if (n >= 1000) begin
      total++;
      bad++;
      $display("FAIL run_until: count %0d not reached within 1000 cycles", target);
    end
  endtask

  // Monitor: compare every post-edge observation with the predicted one.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{cnt: counter, cond: condition, wrp: wrap, appl: cfg_applied,
              err: cfg_err, rdy: cfg_ready};
        cyc++;
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs cycle %0d: got cnt=%0d cond=%0d wrap=%b appl=%b err=%b rdy=%b, want cnt=%0d cond=%0d wrap=%b appl=%b err=%b rdy=%b",
                   cyc, a.cnt, a.cond, a.wrp, a.appl, a.err, a.rdy,
                   e.cnt, e.cond, e.wrp, e.appl, e.err, e.rdy);
        end
      end
    end
  end

  initial begin
    int unsigned rp;
    // Reset state, then default period with enable held high.
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    repeat (105) cycle(0, 1, 0, 0, 0);
    // Config in RUN at count 10: pending until the next wrap, then 20-cycle periods.
    run_until(10);
    cycle(0, 1, 1, 20, 5);
    repeat (130) cycle(0, 1, 0, 0, 0);
    // Config in IDLE applies at once; comparator high for 4 of every 8 cycles.
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 8, 3);
    repeat (20) cycle(0, 1, 0, 0, 0);
    hi_cnt  = 0;
    measure = 1'b1;
    repeat (8) cycle(0, 1, 0, 0, 0);
    measure = 1'b0;
    total++;
    if (hi_cnt != 4) begin
      bad++;
      $display("FAIL udp_clk_duty: high cycles %0d, want 4", hi_cnt);
    end
    // Invalid configs in IDLE and in RUN.
    cycle(0, 0, 1, 10, 10);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 0);
    repeat (5) cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 5, 7);
    repeat (10) cycle(0, 1, 0, 0, 0);
    // Accept exactly on the rollover edge of a default 100-cycle period.
    cycle(1, 0, 0, 0, 0);
    run_until(99);
    cycle(0, 1, 1, 50, 20);
    repeat (260) cycle(0, 1, 0, 0, 0);
    // enable drop while ARMED applies the pending config.
    run_until(3);
    cycle(0, 1, 1, 6, 2);
    repeat (2) cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 0);
    // Reset while ARMED drops the pending config without pulses.
    run_until(2);
    cycle(0, 1, 1, 7, 1);
    cycle(0, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    repeat (120) cycle(0, 1, 0, 0, 0);
    // Randomized traffic with short periods so wraps and collisions are frequent.
    repeat (2500) begin
      rp = $urandom_range(0, 40);
      cycle(($urandom % 400) == 0, ($urandom % 25) != 0, ($urandom % 6) == 0,
            rp, $urandom_range(0, rp + 3));
    end
    cycle(0, 1, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d predictions left unchecked, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
